uart_tx_frame: RTL

- Serial transmit stage downstream of the UART configuration register file.
- Consumes the live frame configuration (parity, parity_type, stop_bits, frame_length) and a parallel data word via a valid/ready handshake.
- Emits an asynchronous serial frame on tx: start bit, N data bits LSB first, optional parity bit, then 1 or 2 stop bits.
- Runs on the 16x baud clock, so each bit lasts 16 clock cycles.

---
 rtl/uart_tx_frame.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_frame.sv
// UART serial transmit stage: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Optional line-break control is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_frame #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_MAX   = 9
) (
    input  logic                clk_16bd,
    input  logic                rst_n,
    input  logic                tx_valid,
    input  logic [DATA_MAX-1:0] tx_data,
    input  logic                parity,
    input  logic                parity_type,
    input  logic                stop_bits,
    input  logic [3:0]          frame_length,
`ifdef UART_TX_BREAK_EN
    input  logic                tx_break,
`endif
    output logic                tx_ready,
    output logic                tx_busy,
    output logic                tx_done,
    output logic                tx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] LEN_MIN   = 4'd5;
    localparam logic [3:0] LEN_MAX   = 4'(DATA_MAX);

    state_t              state_q, state_d;
    logic [3:0]          tick_q, tick_d;
    logic [3:0]          bit_q, bit_d;
    logic                stop_cnt_q, stop_cnt_d;
    logic [DATA_MAX-1:0] sh_q, sh_d;
    logic [3:0]          len_q, len_d;
    logic                par_en_q, par_en_d;
    logic                par_bit_q, par_bit_d;
    logic                stop2_q, stop2_d;
    logic                tx_q, tx_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [3:0]          eff_len;
    logic [DATA_MAX-1:0] all_ones;
    logic [DATA_MAX-1:0] data_masked;
    logic                tick_wrap;
    logic                break_req;

    assign all_ones    = '1;
    assign eff_len     = (frame_length < LEN_MIN) ? LEN_MIN :
                         (frame_length > LEN_MAX) ? LEN_MAX : frame_length;
    // Bits above the effective length are cleared so they neither reach tx nor the parity.
    assign data_masked = tx_data & ~(all_ones << eff_len);
    assign tick_wrap   = (tick_q == TICK_LAST);

`ifdef UART_TX_BREAK_EN
    assign break_req = tx_break;
`else
    assign break_req = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        stop_cnt_d = stop_cnt_q;
        sh_d       = sh_q;
        len_d      = len_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        tx_d       = tx_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d       = 1'b1;
                ready_d    = 1'b1;
                busy_d     = 1'b0;
                tick_d     = '0;
                bit_d      = '0;
                stop_cnt_d = 1'b0;
                if (break_req) begin
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                end else if (tx_valid && ready_q) begin
                    state_d   = S_START;
                    tx_d      = 1'b0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                    sh_d      = data_masked;
                    len_d     = eff_len;
                    par_en_d  = parity;
                    par_bit_d = (^data_masked) ^ parity_type;
                    stop2_d   = stop_bits;
                end
            end
            S_START: begin
                tick_d = tick_q + 4'd1;
                if (tick_wrap) begin
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                    tx_d    = sh_q[0];
                    sh_d    = sh_q >> 1;
                end
            end
            S_DATA: begin
                tick_d = tick_q + 4'd1;
                if (tick_wrap) begin
                    tick_d = '0;
                    if (bit_q == len_q - 4'd1) begin
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d    = S_STOP;
                            tx_d       = 1'b1;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                        tx_d  = sh_q[0];
                        sh_d  = sh_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                tick_d = tick_q + 4'd1;
                if (tick_wrap) begin
                    tick_d     = '0;
                    state_d    = S_STOP;
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                end
            end
            S_STOP: begin
                tick_d = tick_q + 4'd1;
                tx_d   = 1'b1;
                if (tick_wrap) begin
                    tick_d = '0;
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_16bd or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            stop_cnt_q <= 1'b0;
            sh_q       <= '0;
            len_q      <= LEN_MIN;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            stop_cnt_q <= stop_cnt_d;
            sh_q       <= sh_d;
            len_q      <= len_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule
